updi_input_handler_core: RTL and testbench

//  Receive-side data mover for the UPDI programmer. Pulls bytes from the UART RX FIFO
//  and either forwards a requested number of bytes to the output (host) FIFO, or

---
 rtl/updi_input_handler_core.sv | 188 ++++++++++++++++++
 tb/tb_updi_input_handler_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/updi_input_handler_core.sv
// updi_input_handler_core
// Receive-side data mover for the UPDI programmer. Moves bytes from the UART RX
// FIFO to the host response FIFO on request, or consumes one byte and checks it
// against the UPDI ACK value. Every wait for an input byte is guarded by a
// per-byte inactivity timer. All outputs are registered. Each operation ends in
// a one-cycle FINISH state that carries the done/timeout/ack pulse with ready low.
module updi_input_handler_core #(
    parameter int BITS_N       = 6,
    parameter int TIMEOUT_CLKS = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wait_ack,
    output logic              ack_received,
    output logic              ack_error,
    input  logic [BITS_N-1:0] n_bytes,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic              timeout,
    input  logic [7:0]        in_fifo_data,
    input  logic              in_fifo_empty,
    output logic              in_fifo_rd_en,
    output logic [7:0]        out_fifo_data,
    input  logic              out_fifo_full,
    output logic              out_fifo_wr_en
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    // Timer value on the last stalled cycle before the timeout pulse is raised.
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0]     TIMER_ZERO = TW'(0);
    localparam logic [BITS_N-1:0] CNT_ZERO   = BITS_N'(0);
    localparam logic [BITS_N-1:0] CNT_ONE    = BITS_N'(1);
    localparam logic [7:0]        UPDI_ACK   = 8'h40;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FWD_WAIT  = 3'd1,
        FWD_READ  = 3'd2,
        FWD_WRITE = 3'd3,
        ACK_WAIT  = 3'd4,
        ACK_READ  = 3'd5,
        ACK_CHECK = 3'd6,
        FINISH    = 3'd7
    } state_t;

    state_t            state_r, state_s;
    logic [BITS_N-1:0] remaining_r, remaining_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic              ready_r, ready_s;
    logic              done_r, done_s;
    logic              timeout_r, timeout_s;
    logic              ack_received_r, ack_received_s;
    logic              ack_error_r, ack_error_s;
    logic              rd_en_r, rd_en_s;
    logic              wr_en_r, wr_en_s;
    logic [7:0]        out_data_r, out_data_s;

    // Next-state, counter and registered-output decode for the transfer FSM.
    always_comb begin
        state_s        = state_r;
        remaining_s    = remaining_r;
        timer_s        = timer_r;
        done_s         = 1'b0;
        timeout_s      = 1'b0;
        ack_received_s = 1'b0;
        ack_error_s    = 1'b0;
        rd_en_s        = 1'b0;
        wr_en_s        = 1'b0;
        out_data_s     = out_data_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    remaining_s = n_bytes;
                    timer_s     = TIMER_ZERO;
                    if (n_bytes == CNT_ZERO) begin
                        done_s  = 1'b1;
                        state_s = FINISH;
                    end else begin
                        state_s = FWD_WAIT;
                    end
                end else if (wait_ack) begin
                    timer_s = TIMER_ZERO;
                    state_s = ACK_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            FWD_WAIT: begin
                // A write still in flight has not yet been reflected in
                // out_fifo_full, so hold off reading for that one cycle.
                if (!in_fifo_empty && !out_fifo_full && !wr_en_r) begin
                    rd_en_s = 1'b1;
                    timer_s = TIMER_ZERO;
                    state_s = FWD_READ;
                end else if (timer_r == TIMER_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = FINISH;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            FWD_READ: begin
                state_s = FWD_WRITE;
            end
            FWD_WRITE: begin
                wr_en_s     = 1'b1;
                out_data_s  = in_fifo_data;
                remaining_s = remaining_r - CNT_ONE;
                if (remaining_r == CNT_ONE) begin
                    done_s  = 1'b1;
                    state_s = FINISH;
                end else begin
                    state_s = FWD_WAIT;
                end
            end
            ACK_WAIT: begin
                if (!in_fifo_empty) begin
                    rd_en_s = 1'b1;
                    timer_s = TIMER_ZERO;
                    state_s = ACK_READ;
                end else if (timer_r == TIMER_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = FINISH;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ACK_READ: begin
                state_s = ACK_CHECK;
            end
            ACK_CHECK: begin
                ack_received_s = 1'b1;
                ack_error_s    = (in_fifo_data != UPDI_ACK);
                state_s        = FINISH;
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        ready_s = (state_s == IDLE);
    end

    // State, counters and all outputs registered; async reset returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            remaining_r    <= CNT_ZERO;
            timer_r        <= TIMER_ZERO;
            ready_r        <= 1'b1;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
            ack_received_r <= 1'b0;
            ack_error_r    <= 1'b0;
            rd_en_r        <= 1'b0;
            wr_en_r        <= 1'b0;
            out_data_r     <= 8'h00;
        end else begin
            state_r        <= state_s;
            remaining_r    <= remaining_s;
            timer_r        <= timer_s;
            ready_r        <= ready_s;
            done_r         <= done_s;
            timeout_r      <= timeout_s;
            ack_received_r <= ack_received_s;
            ack_error_r    <= ack_error_s;
            rd_en_r        <= rd_en_s;
            wr_en_r        <= wr_en_s;
            out_data_r     <= out_data_s;
        end
    end

    assign ready          = ready_r;
    assign done           = done_r;
    assign timeout        = timeout_r;
    assign ack_received   = ack_received_r;
    assign ack_error      = ack_error_r;
    assign in_fifo_rd_en  = rd_en_r;
    assign out_fifo_wr_en = wr_en_r;
    assign out_fifo_data  = out_data_r;

endmodule

// File: tb/tb_updi_input_handler_core.sv
// Testbench for updi_input_handler_core. Queue-based RX and host FIFO models;
// expected outcomes come from byte counts available at request time.
module tb_updi_input_handler_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wait_ack = 1'b0;
    logic       start = 1'b0;
    logic [5:0] n_bytes = 6'd0;
    logic       ack_received, ack_error, ready, done, timeout;
    logic [7:0] in_fifo_data = 8'h00;
    logic       in_fifo_empty = 1'b1;
    logic       in_fifo_rd_en;
    logic [7:0] out_fifo_data;
    logic       out_fifo_full = 1'b0;
    logic       out_fifo_wr_en;

    logic [7:0] rx_q[$];
    logic [7:0] out_q[$];
    logic [7:0] got_q[$];
    int         cap = 4;
    bit         drain_en = 1'b1;
    int         checks = 0;
    int         errors = 0;

    updi_input_handler_core #(.BITS_N(6), .TIMEOUT_CLKS(25)) dut (
        .clk(clk), .rst(rst), .wait_ack(wait_ack), .ack_received(ack_received),
        .ack_error(ack_error), .n_bytes(n_bytes), .start(start), .ready(ready),
        .done(done), .timeout(timeout), .in_fifo_data(in_fifo_data),
        .in_fifo_empty(in_fifo_empty), .in_fifo_rd_en(in_fifo_rd_en),
        .out_fifo_data(out_fifo_data), .out_fifo_full(out_fifo_full),
        .out_fifo_wr_en(out_fifo_wr_en)
    );

    always #5 clk = ~clk;

    // FIFO models, updated mid-cycle so the DUT sees stable flags at each rising edge.
    always @(negedge clk) begin
        if (in_fifo_rd_en) begin
            checks++;
            assert (rx_q.size() > 0) else begin
                errors++;
                $error("FAIL rx_underflow observed empty read required nonempty");
            end
            if (rx_q.size() > 0) in_fifo_data <= rx_q.pop_front();
        end
        if (out_fifo_wr_en) begin
            checks++;
            assert (out_q.size() < cap) else begin
                errors++;
                $error("FAIL out_overflow observed %0d entries required < %0d", out_q.size(), cap);
            end
            if (out_q.size() < cap) out_q.push_back(out_fifo_data);
        end
        if (drain_en && out_q.size() > 0 && $urandom_range(0, 1) == 1)
            got_q.push_back(out_q.pop_front());
        in_fifo_empty = (rx_q.size() == 0);
        out_fifo_full = (out_q.size() >= cap);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check it against the count-based expectation.
    task automatic run_op(input bit is_ack, input int n);
        int         avail;
        int         e;
        int         budget;
        int         exp_kind;
        int         got_kind;
        bit         exp_err;
        bit         seen;
        logic [7:0] exp_q[$];
        avail   = rx_q.size();
        exp_err = 1'b0;
        if (is_ack) begin
            if (avail >= 1) begin
                exp_kind = 2;
                exp_err  = (rx_q[0] !== 8'h40);
            end else begin
                exp_kind = 1;
            end
        end else begin
            exp_kind = (avail >= n) ? 0 : 1;
            for (int i = 0; i < n && i < avail; i++) exp_q.push_back(rx_q[i]);
        end
        @(negedge clk);
        chk("ready_before", ready, 1);
        if (is_ack) wait_ack = 1'b1;
        else begin
            start   = 1'b1;
            n_bytes = n[5:0];
        end
        @(negedge clk);
        start    = 1'b0;
        wait_ack = 1'b0;
        e        = 0;
        seen     = 1'b0;
        budget   = 30 * (n + 2) + 50;
        while (!seen && e <= budget) begin
            if (done || timeout || ack_received) seen = 1'b1;
            else begin
                @(negedge clk);
                e++;
            end
        end
        chk("op_finished", seen, 1);
        if (seen) begin
            got_kind = done ? 0 : (timeout ? 1 : 2);
            chk("pulse_kind", got_kind, exp_kind);
            chk("pulse_onehot", 32'(done) + 32'(timeout) + 32'(ack_received), 1);
            chk("ready_in_pulse", ready, 0);
            if (exp_kind == 2) chk("ack_error", ack_error, exp_err);
            if (avail == 0 && (is_ack || n > 0)) chk("timeout_cycles", e, 25);
            if (!is_ack && n == 0) chk("zero_len_latency", e, 0);
            @(negedge clk);
            chk("ready_after", ready, 1);
            chk("pulse_cleared", done | timeout | ack_received, 0);
        end
        repeat (30) @(negedge clk);
        chk("out_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("out_byte", got_q[i], exp_q[i]);
        got_q.delete();
    endtask

    initial begin
        int         n;
        int         k;
        bit         is_ack;
        int         e;
        logic [7:0] b;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ack", ack_received, 0);
        chk("rst_ack_err", ack_error, 0);
        chk("rst_rd_en", in_fifo_rd_en, 0);
        chk("rst_wr_en", out_fifo_wr_en, 0);
        chk("rst_out_data", out_fifo_data, 0);
        rst = 1'b1;

        // Directed sequence: F0, 40, F1..F9
        rx_q = '{8'hF0, 8'h40, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF9};
        run_op(1'b0, 1);
        run_op(1'b1, 0);
        run_op(1'b0, 9);
        chk("rx_drained", rx_q.size(), 0);
        run_op(1'b0, 1);
        run_op(1'b1, 0);
        rx_q.push_back(8'h55);
        run_op(1'b1, 0);
        run_op(1'b0, 0);

        // Output FIFO full: forward stalls and finally times out without overflow
        cap      = 2;
        drain_en = 1'b0;
        rx_q     = '{8'hA1, 8'hA2, 8'hA3};
        @(negedge clk);
        start   = 1'b1;
        n_bytes = 6'd3;
        @(negedge clk);
        start = 1'b0;
        e     = 0;
        while (!timeout && !done && e < 200) begin
            @(negedge clk);
            e++;
        end
        chk("full_timeout", timeout, 1);
        chk("full_no_done", done, 0);
        repeat (3) @(negedge clk);
        chk("full_out_count", out_q.size(), 2);
        chk("full_rx_left", rx_q.size(), 1);
        drain_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("full_got_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("full_byte0", got_q[0], 8'hA1);
            chk("full_byte1", got_q[1], 8'hA2);
        end
        got_q.delete();
        rx_q.delete();

        // Randomized operations
        for (int it = 0; it < 40; it++) begin
            rx_q.delete();
            cap    = $urandom_range(1, 4);
            is_ack = ($urandom_range(0, 3) == 0);
            n      = $urandom_range(0, 12);
            if (is_ack) k = $urandom_range(0, 2);
            else if ($urandom_range(0, 3) == 0) k = $urandom_range(0, n);
            else k = n + $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                b = ($urandom_range(0, 2) == 0) ? 8'h40 : 8'($urandom);
                rx_q.push_back(b);
            end
            run_op(is_ack, n);
        end

        // Reset mid-transfer discards the operation
        cap  = 4;
        rx_q = '{8'h11, 8'h22, 8'h33};
        @(negedge clk);
        start   = 1'b1;
        n_bytes = 6'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_rd_en", in_fifo_rd_en, 0);
        chk("midrst_wr_en", out_fifo_wr_en, 0);
        chk("midrst_out_data", out_fifo_data, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        out_q.delete();
        got_q.delete();
        repeat (2) @(negedge clk);
        run_op(1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
